// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: zero-fill sweep after reset / clear_req, then
// round-robin arbitration among NUM_REQ writers. Option: RF_ZERO_REG_EN (register 0 reads as zero, never written after the sweep).
module rf_write_arbiter #(
    parameter int DATA_N  = 32,
    parameter int SIZE    = 32,
    parameter int NUM_REQ = 3,
    localparam int ADDR_W = $clog2(SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_N-1:0] req_data,
    input  logic                      clear_req,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         w_addr,
    output logic [DATA_N-1:0]         w_data,
    output logic                      init_done,
    output logic                      busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic {CLEAR, ARB} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gnt;
    logic              found;
    logic              xfer;
    logic              wr_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_N-1:0] sel_data;
    int unsigned       idx;

    // Rotating priority search starting at the pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ARB && !clear_req && found)
            req_ready[gnt] = 1'b1;
    end

    assign xfer     = |(req_valid & req_ready);
    assign sel_addr = req_addr[gnt*ADDR_W +: ADDR_W];
    assign sel_data = req_data[gnt*DATA_N +: DATA_N];

`ifdef RF_ZERO_REG_EN
    assign wr_ok = (sel_addr != '0);
`else
    assign wr_ok = 1'b1;
`endif

    assign busy      = (state == CLEAR);
    assign init_done = (state == ARB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            ptr    <= '0;
            wr_en  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    // cnt reaches SIZE one edge after the last sweep write.
                    if (cnt == CNT_W'(SIZE)) begin
                        state <= ARB;
                        wr_en <= 1'b0;
                    end else begin
                        wr_en  <= 1'b1;
                        w_addr <= cnt[ADDR_W-1:0];
                        w_data <= '0;
                        cnt    <= cnt + 1'b1;
                    end
                end
                ARB: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        wr_en <= 1'b0;
                    end else if (xfer) begin
                        wr_en  <= wr_ok;
                        w_addr <= sel_addr;
                        w_data <= sel_data;
                        ptr    <= (gnt == PTR_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset sweep, arbitration vector table,
// clear_req re-sweep with pointer retention, and async reset mid-sweep.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        clear_req;
    logic        wr_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        init_done;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    rf_write_arbiter #(.DATA_N(32), .SIZE(32), .NUM_REQ(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .clear_req(clear_req),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic        clr;
        logic [2:0]  rdy;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ad;     // compare w_addr/w_data too
        logic        busy;
        logic        init;
    } vec_t;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Call at a negedge with all requesters valid; returns just after the final edge.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 32; i++) begin
            #1 chk({tag, " sweep ready"}, 96'(req_ready), 96'(3'b000));
            @(posedge clk);
            #1;
            chk({tag, " sweep wr_en"}, 96'(wr_en), 96'(1'b1));
            chk({tag, " sweep w_addr"}, 96'(w_addr), 96'(i));
            chk({tag, " sweep w_data"}, 96'(w_data), 96'(0));
            chk({tag, " sweep busy"}, 96'(busy), 96'(1'b1));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk({tag, " done wr_en"}, 96'(wr_en), 96'(1'b0));
        chk({tag, " done init"}, 96'(init_done), 96'(1'b1));
        chk({tag, " done busy"}, 96'(busy), 96'(1'b0));
    endtask

    localparam logic [14:0] A0 = {5'd7, 5'd6, 5'd5};
    localparam logic [95:0] D0 = {32'hC, 32'hB, 32'hA};
    localparam logic [14:0] A1 = {5'd7, 5'd0, 5'd5};
    localparam logic [95:0] D1 = {32'hC, 32'hFFFF_FFFF, 32'hA};

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{3'b111, A0, D0, 1'b0, 3'b001, 1'b1, 5'd5, 32'hA, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{3'b111, A0, D0, 1'b0, 3'b010, 1'b1, 5'd6, 32'hB, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{3'b111, A0, D0, 1'b0, 3'b100, 1'b1, 5'd7, 32'hC, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{3'b111, A0, D0, 1'b0, 3'b001, 1'b1, 5'd5, 32'hA, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{3'b111, A0, D0, 1'b0, 3'b010, 1'b1, 5'd6, 32'hB, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{3'b111, A0, D0, 1'b0, 3'b100, 1'b1, 5'd7, 32'hC, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{3'b000, A0, D0, 1'b0, 3'b000, 1'b0, 5'd7, 32'hC, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{3'b100, A0, D0, 1'b0, 3'b100, 1'b1, 5'd7, 32'hC, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{3'b010, A0, D0, 1'b0, 3'b010, 1'b1, 5'd6, 32'hB, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{3'b011, A0, D0, 1'b0, 3'b001, 1'b1, 5'd5, 32'hA, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{3'b101, A0, D0, 1'b0, 3'b100, 1'b1, 5'd7, 32'hC, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3'b010, A1, D1, 1'b0, 3'b010, !ZR, 5'd0, 32'hFFFF_FFFF, !ZR, 1'b0, 1'b1};
        tbl[12] = '{3'b011, A0, D0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_addr  = A0;
        req_data  = D0;
        clear_req = 1'b0;
        #12;
        chk("rst wr_en", 96'(wr_en), 96'(1'b0));
        chk("rst w_addr", 96'(w_addr), 96'(0));
        chk("rst w_data", 96'(w_data), 96'(0));
        chk("rst init", 96'(init_done), 96'(1'b0));
        chk("rst busy", 96'(busy), 96'(1'b1));
        chk("rst ready", 96'(req_ready), 96'(3'b000));

        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("init");

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            req_valid = tbl[v].valid;
            req_addr  = tbl[v].addr;
            req_data  = tbl[v].data;
            clear_req = tbl[v].clr;
            #1 chk($sformatf("v%0d ready", v), 96'(req_ready), 96'(tbl[v].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wr_en", v), 96'(wr_en), 96'(tbl[v].wr));
            chk($sformatf("v%0d busy", v), 96'(busy), 96'(tbl[v].busy));
            chk($sformatf("v%0d init", v), 96'(init_done), 96'(tbl[v].init));
            if (tbl[v].ad) begin
                chk($sformatf("v%0d w_addr", v), 96'(w_addr), 96'(tbl[v].waddr));
                chk($sformatf("v%0d w_data", v), 96'(w_data), 96'(tbl[v].wdata));
            end
        end

        // Re-sweep after clear_req, with all requesters still asking.
        @(negedge clk);
        clear_req = 1'b0;
        req_valid = 3'b111;
        req_addr  = A0;
        req_data  = D0;
        sweep_check("clr");

        // Pointer was 2 before the clear and must survive it.
        @(negedge clk);
        #1 chk("ptr kept ready", 96'(req_ready), 96'(3'b100));
        @(posedge clk);
        #1;
        chk("ptr kept wr_en", 96'(wr_en), 96'(1'b1));
        chk("ptr kept w_addr", 96'(w_addr), 96'(5'd7));
        chk("ptr kept w_data", 96'(w_data), 96'(32'hC));

        // Async reset in the middle of a sweep.
        @(negedge clk);
        clear_req = 1'b1;
        #1 chk("clr2 ready", 96'(req_ready), 96'(3'b000));
        @(posedge clk);
        #1 chk("clr2 wr_en", 96'(wr_en), 96'(1'b0));
        @(negedge clk);
        clear_req = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk);
            #1;
            chk("mid w_addr", 96'(w_addr), 96'(i));
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async wr_en", 96'(wr_en), 96'(1'b0));
        chk("async w_addr", 96'(w_addr), 96'(0));
        chk("async busy", 96'(busy), 96'(1'b1));
        chk("async ready", 96'(req_ready), 96'(3'b000));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart wr_en", 96'(wr_en), 96'(1'b1));
        chk("restart w_addr", 96'(w_addr), 96'(0));
        @(posedge clk);
        #1 chk("restart w_addr1", 96'(w_addr), 96'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
